iir_biquad_seq: RTL and testbench
=================================

# iir_biquad_seq

Sequencer for one Direct-Form-I biquad section: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
- Accepts one input sample per handshake and issues the five products, one at a time, to the shared sequential signed multiplier over its start/ready interface.
- Accumulates the products, then rounds, saturates and emits the output sample.
- Sits directly in front of and behind the multiplier: it feeds the multiplier's operands and consumes its products.

## Interface
- W, 8, sample and coefficient width (signed two's complement); multiplier opsize = W
- FRAC, 6, coefficient fractional bits (1.0 = 2^FRAC)
- ACC_W, 2*W+4, accumulator width (signed)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  high only in IDLE
- in_data  in  W  x[n], signed
- b0, b1, b2, a1, a2  in  W each  coefficients, signed QFRAC
- out_valid  out  1  one-cycle pulse, y[n] valid
- out_data  out  W  y[n], signed, held until next pulse
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a, mul_b  out  W each  multiplier operands (sample, coefficient)
- mul_p  in  2W  signed product from multiplier
- mul_ready  in  1  multiplier idle / product valid

## Operation
- States: IDLE, ISSUE, BUSY, OUT. Term index k = 0..4 (3-bit).
- Term table:
  - k0: (x0, b0), add
  - k1: (x1, b1), add
  - k2: (x2, b2), add
  - k3: (y1, a1), subtract
  - k4: (y2, a2), subtract
- IDLE:
  - in_ready=1.
  - On in_valid: capture x0 ← in_data, acc ← 0, k ← 0, go to ISSUE.
- ISSUE:
  - Waits while mul_ready=0.
  - When mul_ready=1: mul_start=1, mul_a/mul_b ← term-k operands (coefficient sampled here), clear seen_low, go to BUSY.
  - mul_a/mul_b hold until the next ISSUE.
- BUSY:
  - Sets seen_low when mul_ready=0.
  - On mul_ready=1 with seen_low set (or set this cycle): acc ← acc ± sign_ext(mul_p).
  - Then k==4 → OUT, else k ← k+1 → ISSUE.
  - mul_ready=1 before seen_low is ignored and does not accept a stale product.
- OUT:
  - r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up).
  - Saturate r to [−2^(W−1), 2^(W−1)−1], giving y.
  - out_data ← y, out_valid=1 for this cycle.
  - Delay line update: x2←x1, x1←x0, y2←y1, y1←y (y1 stores the saturated value).
  - Go to IDLE.
- in_valid while in_ready=0 is ignored; no sample is queued.
- Coefficients must be stable for a whole sample; a change affects only terms not yet issued.
- Reset (any state, including mid-term):
  - State goes to IDLE; acc, k, x0..x2, y1, y2 clear to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, mul_start=0, mul_a=0, mul_b=0.
  - No out_valid for the aborted sample. The multiplier shares reset.

## Timing
- Multiplier contract: mul_ready falls the cycle after mul_start, then stays low L cycles (L = W+1 for the team multiplier) before mul_p is valid with mul_ready=1.
- Per term: 1 ISSUE cycle + L low cycles + 1 accept cycle = L+2 cycles.
- Latency: acceptance cycle (IDLE, in_valid=1) to out_valid = 5(L+2)+1 cycles. For W=8 this is 56.
- Throughput: one sample per 5(L+2)+2 cycles. in_ready returns high the cycle after out_valid.
- mul_start is never high in two consecutive cycles, and never while mul_ready=0.

## Test plan
- Pass-through: b0=64, others 0; x=5 → y=5; x=−7 → y=−7.
  - out_valid exactly 56 cycles after acceptance.
  - mul_start pulses exactly 5 times per sample.
- Pure delay: b1=64, others 0; x=10, 20, 30 → y=0, 10, 20.
- Feedback: b0=64, a1=32, others 0; impulse x=64, 0, 0, 0 → y=64, −32, 16, −8.
- Saturation: b0=127, others 0.
  - x=127: 16129+32 = 16161, >>>6 gives 252 → y=127.
  - x=−128: −16256+32 = −16224, >>>6 gives −254 → y=−128.
- Rounding: b0=32, others 0; x=3 → y=2; x=−3 → y=−1.
- Handshake/reset:
  - in_valid held high while busy → only one sample consumed per out_valid.
  - Assert reset during term k=3 → no out_valid for that sample; in_ready=1 the next cycle.
  - Then b1=64, others 0, x=9 → y=0 (delay line cleared).

Source files
------------

// File: rtl/iir_biquad_seq_if.sv
// Handshake and multiplier bus for the biquad sequencer.
// master = the sequencer, slave = its environment (sample source/sink
// plus the shared sequential multiplier).
interface iir_biquad_seq_if #(
  parameter int W = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic signed [W-1:0]   in_data;
  logic                  out_valid;
  logic signed [W-1:0]   out_data;
  logic                  mul_start;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic signed [2*W-1:0] mul_p;
  logic                  mul_ready;

  modport master (
    input  in_valid, in_data, mul_p, mul_ready,
    output in_ready, out_valid, out_data, mul_start, mul_a, mul_b
  );

  modport slave (
    output in_valid, in_data, mul_p, mul_ready,
    input  in_ready, out_valid, out_data, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/iir_biquad_seq.sv
// Direct-Form-I biquad sequencer:
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
// The five products are issued one at a time to a shared sequential
// multiplier, accumulated, then rounded (half up) and saturated to W bits.
module iir_biquad_seq #(
  parameter int W     = 8,
  parameter int FRAC  = 6,
  parameter int ACC_W = 2 * W + 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  iir_biquad_seq_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, OUT} state_t;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(1 << (W - 1)));

  state_t                  state_q;
  logic [2:0]              k_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [W-1:0]     x0_q, x1_q, x2_q, y1_q, y2_q;
  logic                    seen_low_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic signed [W-1:0]     out_data_q;
  logic signed [W-1:0]     mul_a_q, mul_b_q;

  logic signed [W-1:0]     op_x, op_c;
  logic                    op_sub;
  logic                    issue;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_d;

  // Round half up: add half an LSB of the output, then arithmetic shift.
  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] a
  );
    return (a + HALF) >>> FRAC;
  endfunction

  // Clamp to the signed W-bit range.
  function automatic logic signed [W-1:0] saturate(
    input logic signed [ACC_W-1:0] r
  );
    if (r > MAXV) return W'(MAXV);
    if (r < MINV) return W'(MINV);
    return W'(r);
  endfunction

  // Term table: operands and accumulate direction for term k.
  always_comb begin
    op_x   = x0_q;
    op_c   = b0;
    op_sub = 1'b0;
    case (k_q)
      3'd0: begin op_x = x0_q; op_c = b0; op_sub = 1'b0; end
      3'd1: begin op_x = x1_q; op_c = b1; op_sub = 1'b0; end
      3'd2: begin op_x = x2_q; op_c = b2; op_sub = 1'b0; end
      3'd3: begin op_x = y1_q; op_c = a1; op_sub = 1'b1; end
      3'd4: begin op_x = y2_q; op_c = a2; op_sub = 1'b1; end
      default: begin op_x = x0_q; op_c = b0; op_sub = 1'b0; end
    endcase
  end

  // The start pulse and its operands must be visible in the same cycle the
  // multiplier reports idle, so they bypass the operand registers while issuing.
  assign issue    = (state_q == ISSUE) && bus.mul_ready;
  assign prod_ext = ACC_W'(bus.mul_p);
  assign acc_d    = op_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);

  assign bus.mul_start = issue;
  assign bus.mul_a     = issue ? op_x : mul_a_q;
  assign bus.mul_b     = issue ? op_c : mul_b_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Sequencer FSM: accept sample, issue/collect five terms, emit result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      acc_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      seen_low_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x0_q       <= bus.in_data;
            acc_q      <= '0;
            k_q        <= 3'd0;
            in_ready_q <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            mul_a_q    <= op_x;
            mul_b_q    <= op_c;
            seen_low_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // A ready seen before the multiplier has dropped it belongs to the
          // previous product and must not be accumulated.
          if (!bus.mul_ready) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            acc_q <= acc_d;
            if (k_q == 3'd4) begin
              out_data_q  <= saturate(round_shift(acc_d));
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              k_q     <= k_q + 3'd1;
              state_q <= ISSUE;
            end
          end
        end
        OUT: begin
          // Feedback taps keep the saturated output, as emitted.
          out_valid_q <= 1'b0;
          x2_q        <= x1_q;
          x1_q        <= x0_q;
          y2_q        <= y1_q;
          y1_q        <= out_data_q;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Bench for iir_biquad_seq: directed vectors against a behavioural
// sequential multiplier (ready drops the cycle after start, stays low L cycles).
module tb_iir_biquad_seq;
  localparam int W   = 8;
  localparam int L   = W + 1;
  localparam int LAT = 5 * (L + 2) + 1;

  typedef struct {
    bit                  rst;
    logic signed [W-1:0] c0, c1, c2, c3, c4;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [W-1:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;

  iir_biquad_seq_if #(.W(W)) bus ();

  iir_biquad_seq #(.W(W), .FRAC(6), .ACC_W(2 * W + 4)) dut (
    .clk   (clk),
    .reset (reset),
    .b0    (b0),
    .b1    (b1),
    .b2    (b2),
    .a1    (a1),
    .a2    (a2),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Multiplier model; product bus carries junk while busy.
  int                    m_cnt;
  logic signed [2*W-1:0] m_prod;
  always @(posedge clk) begin
    if (reset) begin
      bus.mul_ready <= 1'b1;
      bus.mul_p     <= '0;
      m_cnt         <= 0;
    end else if (bus.mul_start && bus.mul_ready) begin
      bus.mul_ready <= 1'b0;
      bus.mul_p     <= 16'sh5a5a;
      m_prod        <= bus.mul_a * bus.mul_b;
      m_cnt         <= L;
    end else if (!bus.mul_ready) begin
      if (m_cnt == 1) begin
        bus.mul_ready <= 1'b1;
        bus.mul_p     <= m_prod;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Start-pulse protocol monitor and pulse counter.
  int   n_starts = 0;
  int   mon_err  = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mul_start && prev_start) begin
        $display("FAIL mul_start_back_to_back at %0t: got two, want one", $time);
        mon_err <= mon_err + 1;
      end
      if (bus.mul_start && !bus.mul_ready) begin
        $display("FAIL mul_start_while_busy at %0t: got start with ready=0, want none", $time);
        mon_err <= mon_err + 1;
      end
      n_starts <= n_starts + (bus.mul_start ? 1 : 0);
    end
    prev_start <= bus.mul_start;
  end

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({name, "_in_ready"}, int'(bus.in_ready), 1);
  endtask

  // Apply one sample and check result, latency and multiplier usage.
  task automatic run_one(input string name, input logic signed [W-1:0] x,
                         input logic signed [W-1:0] want);
    int cnt = 0;
    int s0;
    bit got = 0;
    wait_ready(name);
    bus.in_data  = x;
    bus.in_valid = 1'b1;
    s0 = n_starts;
    while (!got && cnt < 200) begin
      @(negedge clk);
      cnt++;
      bus.in_valid = 1'b0;
      if (bus.out_valid) got = 1;
    end
    check({name, "_y"}, got ? int'(bus.out_data) : 9999, int'(want));
    check({name, "_latency"}, cnt, LAT);
    @(negedge clk);
    check({name, "_starts"}, n_starts - s0, 5);
  endtask

  function automatic vec_t mk(bit r, int c0, int c1, int c2, int c3, int c4,
                              int x, int y);
    vec_t v;
    v.rst = r;
    v.c0 = W'(c0); v.c1 = W'(c1); v.c2 = W'(c2); v.c3 = W'(c3); v.c4 = W'(c4);
    v.x = W'(x);
    v.y = W'(y);
    return v;
  endfunction

  vec_t tab[15];

  initial begin
    int pulses, p1, p2, cnt;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    //        rst b0  b1  b2 a1 a2   x     y
    tab[0]  = mk(1, 64,  0, 0,  0, 0,    5,    5);
    tab[1]  = mk(0, 64,  0, 0,  0, 0,   -7,   -7);
    tab[2]  = mk(1,  0, 64, 0,  0, 0,   10,    0);
    tab[3]  = mk(0,  0, 64, 0,  0, 0,   20,   10);
    tab[4]  = mk(0,  0, 64, 0,  0, 0,   30,   20);
    tab[5]  = mk(1, 64,  0, 0, 32, 0,   64,   64);
    tab[6]  = mk(0, 64,  0, 0, 32, 0,    0,  -32);
    tab[7]  = mk(0, 64,  0, 0, 32, 0,    0,   16);
    tab[8]  = mk(0, 64,  0, 0, 32, 0,    0,   -8);
    tab[9]  = mk(1, 127, 0, 0,  0, 0,  127,  127);
    tab[10] = mk(0, 127, 0, 0,  0, 0, -128, -128);
    tab[11] = mk(1, 32,  0, 0,  0, 0,    3,    2);
    tab[12] = mk(0, 32,  0, 0,  0, 0,   -3,   -1);
    tab[13] = mk(1, 64, 64, 0,  0, 0,   40,   40);
    tab[14] = mk(0, 64, 64, 0,  0, 0,   -1,   39);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  int'(bus.in_ready),  1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data",  int'(bus.out_data),  0);
    check("rst_mul_start", int'(bus.mul_start), 0);
    check("rst_mul_a",     int'(bus.mul_a),     0);
    check("rst_mul_b",     int'(bus.mul_b),     0);

    for (int i = 0; i < 15; i++) begin
      if (tab[i].rst) do_reset();
      b0 = tab[i].c0; b1 = tab[i].c1; b2 = tab[i].c2;
      a1 = tab[i].c3; a2 = tab[i].c4;
      run_one($sformatf("vec%0d", i), tab[i].x, tab[i].y);
    end

    // in_valid held high while busy: one sample per out_valid.
    do_reset();
    b0 = 8'sd64; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    wait_ready("hold");
    bus.in_data  = 8'sd11;
    bus.in_valid = 1'b1;
    pulses = 0; p1 = 0; p2 = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 61) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        pulses++;
        if (pulses == 1) p1 = c;
        if (pulses == 2) p2 = c;
        check("hold_y", int'(bus.out_data), 11);
      end
    end
    check("hold_pulses", pulses, 2);
    check("hold_first",  p1, LAT);
    check("hold_second", p2, 2 * LAT + 1);

    // Reset while term k=3 is in the multiplier aborts the sample.
    do_reset();
    b0 = '0; b1 = 8'sd64; b2 = '0; a1 = '0; a2 = '0;
    run_one("pre", 8'sd50, 8'sd0);
    wait_ready("abort");
    bus.in_data  = 8'sd77;
    bus.in_valid = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) pulses++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready",  int'(bus.in_ready),  1);
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_out_data",  int'(bus.out_data),  0);
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("abort_no_pulse", pulses + cnt, 0);
    run_one("cleared", 8'sd9, 8'sd0);

    check("mul_protocol", mon_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

endmodule
